// File: rtl/dmac_pkg.sv
// Shared definitions for the DMAC slave side: register offsets,
// opmode/status bit positions, descriptor layout and widths.
package dmac_pkg;

  localparam int unsigned DESC_W   = 24;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned OPMODE_W = 3;

  // CPU-visible register offsets (decoded on all 8 address bits).
  typedef enum logic [7:0] {
    REG_OPSTART  = 8'h00,
    REG_INT      = 8'h01,
    REG_INT_EN   = 8'h02,
    REG_SRC      = 8'h03,
    REG_DST      = 8'h04,
    REG_SIZE     = 8'h05,
    REG_PUSH     = 8'h06,
    REG_OPMODE   = 8'h07,
    REG_DESC_CNT = 8'h08,
    REG_STATUS   = 8'h09
  } reg_addr_e;

  // opmode bit positions
  localparam int unsigned OPMODE_SRC_INC   = 0;
  localparam int unsigned OPMODE_DST_INC   = 1;
  localparam int unsigned OPMODE_ZERO_FILL = 2;

  // STATUS register bit positions
  localparam int unsigned STATUS_EMPTY    = 0;
  localparam int unsigned STATUS_BUSY     = 1;
  localparam int unsigned STATUS_OVERFLOW = 2;

  typedef struct packed {
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] size;
  } desc_t;

endpackage

// File: rtl/dmac_fifo.sv
// Descriptor FIFO with registered (non-fall-through) output.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, wdata     write request and data; dropped when full unless popping
//   pop             read request; ignored when empty
//   ovf_clr         clears the sticky overflow flag
//   rdata           head entry, loaded on an accepted pop, held otherwise
//   count           number of stored entries
//   full, empty     occupancy flags
//   overflow        sticky: set when a push was dropped
module dmac_fifo
  import dmac_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A pop frees the slot the push needs, so push+pop while full is accepted.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    ovf_d    = ovf_q;
    if (do_pop) begin
      rdata_d  = mem_q[rd_ptr_q];
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (push & ~do_push) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible after being pushed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata    = rdata_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/dmac_slave.sv
// Bus-slave side of the DMA controller: CPU register file, descriptor
// FIFO, start/clear pulses to the master and the maskable done interrupt.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   S_sel, S_wr, S_address,
//   S_din, S_dout                system bus slave port (1-cycle read latency)
//   rd_en                        descriptor pop request from the master
//   source_addr, dest_addr,
//   data_size, data_count        FIFO head descriptor and occupancy
//   opstart, opdone_clear        one-cycle pulses to the master
//   opdone                       master is in DONE
//   opmode                       {zero-fill, dest inc, source inc}
//   interrupt                    int_status & int_enable
module dmac_slave
  import dmac_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                S_sel,
  input  logic                S_wr,
  input  logic [7:0]          S_address,
  input  logic [31:0]         S_din,
  output logic [31:0]         S_dout,
  input  logic                rd_en,
  output logic [7:0]          source_addr,
  output logic [7:0]          dest_addr,
  output logic [7:0]          data_size,
  output logic [CNT_W-1:0]    data_count,
  output logic                opstart,
  input  logic                opdone,
  output logic                opdone_clear,
  output logic [OPMODE_W-1:0] opmode,
  output logic                interrupt
);

  logic [31:0]         s_dout_q, s_dout_d;
  logic                opstart_q, opstart_d;
  logic                opdone_clear_q, opdone_clear_d;
  logic                busy_q, busy_d;
  logic                int_status_q, int_status_d;
  logic                int_en_q, int_en_d;
  logic [7:0]          src_q, src_d;
  logic [7:0]          dst_q, dst_d;
  logic [7:0]          size_q, size_d;
  logic [OPMODE_W-1:0] opmode_q, opmode_d;

  logic        bus_wr, bus_rd;
  logic        int_clr, start_ok;
  logic        fifo_push, fifo_ovf_clr;
  logic        fifo_full, fifo_empty, fifo_ovf;
  logic [DESC_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  desc_t       head;
  logic [31:0] rdata;
  logic        unused_din;

  assign bus_wr = S_sel & S_wr;
  assign bus_rd = S_sel & ~S_wr;

  assign start_ok     = bus_wr & (S_address == REG_OPSTART) & S_din[0] & ~busy_q;
  assign int_clr      = bus_wr & (S_address == REG_INT) & S_din[0];
  assign fifo_push    = bus_wr & (S_address == REG_PUSH);
  assign fifo_ovf_clr = bus_wr & (S_address == REG_STATUS);

  assign unused_din = ^S_din[31:8];

  dmac_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DESC_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset_n),
    .push     (fifo_push),
    .wdata    ({src_q, dst_q, size_q}),
    .pop      (rd_en),
    .ovf_clr  (fifo_ovf_clr),
    .rdata    (fifo_rdata),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_ovf)
  );

  always_comb begin
    rdata = '0;
    case (S_address)
      REG_INT:      rdata[0] = int_status_q;
      REG_INT_EN:   rdata[0] = int_en_q;
      REG_SRC:      rdata[7:0] = src_q;
      REG_DST:      rdata[7:0] = dst_q;
      REG_SIZE:     rdata[7:0] = size_q;
      REG_OPMODE:   rdata[OPMODE_W-1:0] = opmode_q;
      REG_DESC_CNT: rdata[CNT_W-1:0] = fifo_count;
      REG_STATUS: begin
        rdata[STATUS_EMPTY]    = fifo_empty;
        rdata[STATUS_BUSY]     = busy_q;
        rdata[STATUS_OVERFLOW] = fifo_ovf;
      end
      default: rdata = '0;
    endcase
  end

  always_comb begin
    s_dout_d       = bus_rd ? rdata : '0;
    opstart_d      = start_ok;
    opdone_clear_d = int_clr;
    busy_d         = busy_q;
    int_status_d   = int_status_q;
    int_en_d       = int_en_q;
    src_d          = src_q;
    dst_d          = dst_q;
    size_d         = size_q;
    opmode_d       = opmode_q;

    if (start_ok) begin
      busy_d = 1'b1;
    end
    if (int_clr) begin
      busy_d = 1'b0;
    end

    // The clear wins; while opdone_clear is high the master is still in
    // DONE for one more edge, so that edge must not re-arm the status.
    if (int_clr) begin
      int_status_d = 1'b0;
    end else if (opdone & ~opdone_clear_q) begin
      int_status_d = 1'b1;
    end

    if (bus_wr) begin
      case (S_address)
        REG_INT_EN: int_en_d = S_din[0];
        REG_SRC:    src_d    = S_din[7:0];
        REG_DST:    dst_d    = S_din[7:0];
        REG_SIZE:   size_d   = S_din[7:0];
        REG_OPMODE: if (!busy_q) opmode_d = S_din[OPMODE_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_dout_q       <= '0;
      opstart_q      <= 1'b0;
      opdone_clear_q <= 1'b0;
      busy_q         <= 1'b0;
      int_status_q   <= 1'b0;
      int_en_q       <= 1'b0;
      src_q          <= '0;
      dst_q          <= '0;
      size_q         <= '0;
      opmode_q       <= '0;
    end else begin
      s_dout_q       <= s_dout_d;
      opstart_q      <= opstart_d;
      opdone_clear_q <= opdone_clear_d;
      busy_q         <= busy_d;
      int_status_q   <= int_status_d;
      int_en_q       <= int_en_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      size_q         <= size_d;
      opmode_q       <= opmode_d;
    end
  end

  assign head         = fifo_rdata;
  assign S_dout       = s_dout_q;
  assign source_addr  = head.src;
  assign dest_addr    = head.dst;
  assign data_size    = head.size;
  assign data_count   = fifo_count;
  assign opstart      = opstart_q;
  assign opdone_clear = opdone_clear_q;
  assign opmode       = opmode_q;
  assign interrupt    = int_status_q & int_en_q;

endmodule
